// File: rtl/pla_or_plane_ctrl_reg_pkg.sv
// Shared constants for the control PLA output half: term/control-bit indices and the default OR-plane mask.
package pla_ctrl_pkg;

    localparam int NTERMS = 6;
    localparam int NOUT   = 10;
    localparam int ERRW   = 8;
    localparam int HITW   = $clog2(NTERMS + 1);

    // Product-term indices (AND-plane line order)
    localparam int T_R    = 0;
    localparam int T_LW   = 1;
    localparam int T_SW   = 2;
    localparam int T_BEQ  = 3;
    localparam int T_ADDI = 4;
    localparam int T_J    = 5;

    // Control-word bit positions
    localparam int C_REGDST    = 9;
    localparam int C_ALUSRC    = 8;
    localparam int C_MEMTOREG  = 7;
    localparam int C_REGWRITE  = 6;
    localparam int C_MEMREAD   = 5;
    localparam int C_MEMWRITE  = 4;
    localparam int C_BRANCH    = 3;
    localparam int C_JUMP      = 2;
    localparam int C_ALUOP_HI  = 1;
    localparam int C_ALUOP_LO  = 0;

    // Row t occupies bits [t*NOUT +: NOUT]; term0 (R-type) is the least significant row.
    localparam logic [NTERMS*NOUT-1:0] ORMASK_DEFAULT =
        {10'h004, 10'h140, 10'h009, 10'h110, 10'h1E0, 10'h242};

endpackage

// File: rtl/pla_or_plane_ctrl_reg_if.sv
// Pipeline-side bundle of the control PLA output stage: decoded terms and pipeline controls in, ID/EX fields out.
interface pla_or_plane_ctrl_reg_if;
    import pla_ctrl_pkg::*;

    logic              in_valid;
    logic [NTERMS-1:0] in_terms;
    logic              stall;
    logic              flush;
    logic              err_clr;
    logic [NOUT-1:0]   ctrl_q;
    logic              valid_q;
    logic              illegal_q;
    logic              multi_q;
    logic [ERRW-1:0]   err_cnt;

    modport master (
        output in_valid, in_terms, stall, flush, err_clr,
        input  ctrl_q, valid_q, illegal_q, multi_q, err_cnt
    );

    modport slave (
        input  in_valid, in_terms, stall, flush, err_clr,
        output ctrl_q, valid_q, illegal_q, multi_q, err_cnt
    );
endinterface

// File: rtl/pla_or_plane_ctrl_reg_orp.sv
// Combinational OR plane: one OR column per control bit plus a popcount of active product terms.
module pla_or_plane
    import pla_ctrl_pkg::*;
#(
    parameter int                          P_NTERMS = NTERMS,
    parameter int                          P_NOUT   = NOUT,
    parameter logic [P_NTERMS*P_NOUT-1:0]  P_ORMASK = ORMASK_DEFAULT
) (
    input  logic [P_NTERMS-1:0]          terms,
    output logic [P_NOUT-1:0]            or_word,
    output logic [$clog2(P_NTERMS+1)-1:0] nterms_hit
);

    for (genvar gi = 0; gi < P_NOUT; gi++) begin : g_col
        logic [P_NTERMS-1:0] col;
        for (genvar gt = 0; gt < P_NTERMS; gt++) begin : g_tap
            assign col[gt] = P_ORMASK[gt*P_NOUT + gi];
        end
        assign or_word[gi] = |(terms & col);
    end

    always_comb begin
        nterms_hit = '0;
        for (int t = 0; t < P_NTERMS; t++) begin
            nterms_hit = nterms_hit + {{($clog2(P_NTERMS+1)-1){1'b0}}, terms[t]};
        end
    end

endmodule

// File: rtl/pla_or_plane_ctrl_reg.sv
// ID/EX register for the main-decoder control word with illegal/multi-hit flags and a saturating fault counter.
// Optional PLA_MULTIHIT_CHECK_EN: multi-term hits load a bubble, raise multi_q and count as faults.
module pla_or_plane_ctrl_reg
    import pla_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    pla_or_plane_ctrl_reg_if.slave    bus
);

    logic [NOUT-1:0]   or_word;
    logic [HITW-1:0]   nterms_hit;
    logic [NTERMS-1:0] terms_gated;

    logic [NOUT-1:0] ctrl_d,    ctrl_q;
    logic            valid_d,   valid_q;
    logic            illegal_d, illegal_q;
    logic            multi_d,   multi_q;
    logic [ERRW-1:0] err_d,     err_q;

    // Gating here keeps X on idle term lines out of the plane entirely.
    assign terms_gated = bus.in_valid ? bus.in_terms : '0;

    pla_or_plane #(
        .P_NTERMS (NTERMS),
        .P_NOUT   (NOUT),
        .P_ORMASK (ORMASK_DEFAULT)
    ) u_or_plane (
        .terms      (terms_gated),
        .or_word    (or_word),
        .nterms_hit (nterms_hit)
    );

    logic load;
    logic hit_none;
    logic hit_multi;
    logic fault;

    always_comb begin
        load      = !bus.flush && !bus.stall;
        hit_none  = (nterms_hit == '0);
        hit_multi = (nterms_hit > HITW'(1));

        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        multi_d   = multi_q;
        fault     = 1'b0;

        if (bus.flush) begin
            ctrl_d    = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            multi_d   = 1'b0;
        end else if (load) begin
            valid_d   = bus.in_valid;
            illegal_d = bus.in_valid && hit_none;
            multi_d   = 1'b0;
            ctrl_d    = bus.in_valid ? or_word : '0;
            fault     = bus.in_valid && hit_none;
`ifdef PLA_MULTIHIT_CHECK_EN
            if (bus.in_valid && hit_multi) begin
                ctrl_d  = '0;
                multi_d = 1'b1;
                fault   = 1'b1;
            end
`endif
        end

        // Clear has priority over an increment in the same cycle.
        err_d = err_q;
        if (bus.err_clr) begin
            err_d = '0;
        end else if (fault && (err_q != {ERRW{1'b1}})) begin
            err_d = err_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            multi_q   <= multi_d;
            err_q     <= err_d;
        end
    end

    assign bus.ctrl_q    = ctrl_q;
    assign bus.valid_q   = valid_q;
    assign bus.illegal_q = illegal_q;
    assign bus.multi_q   = multi_q;
    assign bus.err_cnt   = err_q;

    logic unused_hit_multi;
    assign unused_hit_multi = hit_multi;

endmodule

// File: tb/tb_pla_or_plane_ctrl_reg.sv
// Directed bench for pla_or_plane_ctrl_reg; expectations adapt to PLA_MULTIHIT_CHECK_EN.
module tb_pla_or_plane_ctrl_reg;
    import pla_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    pla_or_plane_ctrl_reg_if bus ();

    pla_or_plane_ctrl_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [NTERMS-1:0] t,
                         input logic st, input logic fl, input logic ec);
        bus.in_valid = v;
        bus.in_terms = t;
        bus.stall    = st;
        bus.flush    = fl;
        bus.err_clr  = ec;
    endtask

    task automatic chk_out(input string tag, input logic [NOUT-1:0] c, input logic v,
                           input logic il, input logic mu, input logic [ERRW-1:0] e);
        chk({tag, ".ctrl"},    32'(bus.ctrl_q),    32'(c));
        chk({tag, ".valid"},   32'(bus.valid_q),   32'(v));
        chk({tag, ".illegal"}, 32'(bus.illegal_q), 32'(il));
        chk({tag, ".multi"},   32'(bus.multi_q),   32'(mu));
        chk({tag, ".err"},     32'(bus.err_cnt),   32'(e));
        $display("step %-12s ctrl=%h valid=%b ill=%b multi=%b err=%h", tag,
                 bus.ctrl_q, bus.valid_q, bus.illegal_q, bus.multi_q, bus.err_cnt);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset", 10'h000, 0, 0, 0, 8'h00);
        reset = 1'b0;
        tick();
        chk_out("post_rst", 10'h000, 0, 0, 0, 8'h00);

        // lw then R-type
        drive(1'b1, 6'b000010, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("lw", 10'h1E0, 1, 0, 0, 8'h00);
        drive(1'b1, 6'b000001, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rtype", 10'h242, 1, 0, 0, 8'h00);

        // Asynchronous reset mid-cycle while stalled, checked before the next edge
        drive(1'b1, 6'b000001, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_out("async_rst", 10'h000, 0, 0, 0, 8'h00);
        #1 reset = 1'b0;
        drive(1'b0, 6'b000001, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rst_idle", 10'h000, 0, 0, 0, 8'h00);

        // beq then stall with j on the lines
        drive(1'b1, 6'b001000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("beq", 10'h009, 1, 0, 0, 8'h00);
        drive(1'b1, 6'b100000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall_beq", 10'h009, 1, 0, 0, 8'h00);
        end

        // stall and flush together: flush wins
        drive(1'b1, 6'b100000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("stall_flush", 10'h000, 0, 0, 0, 8'h00);

        // j and addi loads
        drive(1'b1, 6'b100000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("j", 10'h004, 1, 0, 0, 8'h00);
        drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("addi", 10'h140, 1, 0, 0, 8'h00);

        // X on idle term lines must not reach ctrl_q
        drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("idle_x", 10'h000, 0, 0, 0, 8'h00);

        // illegal flag holds through stall; no count while stalled; clear honoured in stall
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("illegal", 10'h000, 1, 1, 0, 8'h01);
        drive(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ill_stall", 10'h000, 1, 1, 0, 8'h01);
        drive(1'b1, 6'b000000, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("clr_stall", 10'h000, 1, 1, 0, 8'h00);

        // flush clears flags and does not count
        drive(1'b1, 6'b000000, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("ill_flush", 10'h000, 0, 0, 0, 8'h00);

        // 300 illegal loads: count saturates at FF
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk("sat.illegal", 32'(bus.illegal_q), 32'd1);
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
                chk("sat.err", 32'(bus.err_cnt), 32'((k > 255) ? 255 : k));
                $display("step sat k=%0d err=%h", k, bus.err_cnt);
            end
        end

        // clear beats same-cycle increment
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("clr_vs_inc", 10'h000, 1, 1, 0, 8'h00);
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("inc_after", 10'h000, 1, 1, 0, 8'h01);
        drive(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("clr_idle", 10'h000, 0, 0, 0, 8'h00);

        // multiple hits: lw|sw
        drive(1'b1, 6'b000110, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef PLA_MULTIHIT_CHECK_EN
        chk_out("multi", 10'h000, 1, 0, 1, 8'h01);
`else
        chk_out("multi", 10'h1F0, 1, 0, 0, 8'h00);
`endif
        drive(1'b1, 6'b000100, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef PLA_MULTIHIT_CHECK_EN
        chk_out("sw", 10'h110, 1, 0, 0, 8'h01);
`else
        chk_out("sw", 10'h110, 1, 0, 0, 8'h00);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
